// File: rtl/pad_in_filter_if.sv
// Pad input filter bus: raw pad levels and per-pad configuration in,
// filtered levels, edge pulses and interrupt status out.
`ifndef N_IO
`define N_IO 50
`endif

interface pad_in_filter_if #(
    parameter int N_IO  = `N_IO,
    parameter int CNT_W = 8
);
    logic [N_IO-1:0]       io_in_i;
    logic [N_IO-1:0]       filt_en_i;
    logic [CNT_W-1:0]      filt_len_i;
    logic [N_IO-1:0]       irq_en_i;
    logic [N_IO-1:0][1:0]  irq_type_i;
    logic [N_IO-1:0]       irq_clr_i;
    logic [N_IO-1:0]       io_filt_o;
    logic [N_IO-1:0]       io_rise_o;
    logic [N_IO-1:0]       io_fall_o;
    logic [N_IO-1:0]       irq_pend_o;
    logic                  irq_o;

    // Side that drives pads and configuration (pad frame / register block)
    modport master (
        output io_in_i, filt_en_i, filt_len_i, irq_en_i, irq_type_i, irq_clr_i,
        input  io_filt_o, io_rise_o, io_fall_o, irq_pend_o, irq_o
    );

    // Filter side
    modport slave (
        input  io_in_i, filt_en_i, filt_len_i, irq_en_i, irq_type_i, irq_clr_i,
        output io_filt_o, io_rise_o, io_fall_o, irq_pend_o, irq_o
    );
endinterface

// File: rtl/pad_in_filter.sv
// Pad input conditioning: per-pad two-flop synchroniser, glitch filter with a
// shared stability length, edge detection and sticky interrupt pending flags.
`ifndef N_IO
`define N_IO 50
`endif

module pad_in_filter #(
    parameter int N_IO  = `N_IO,
    parameter int CNT_W = 8
) (
    input logic            clk_i,
    input logic            rst_ni,
    pad_in_filter_if.slave bus
);
    logic [N_IO-1:0]  sync1;
    logic [N_IO-1:0]  sync2;
    logic [N_IO-1:0]  filt;
    logic [N_IO-1:0]  filt_d;
    logic [N_IO-1:0]  pend;
    logic [N_IO-1:0]  rise;
    logic [N_IO-1:0]  fall;
    logic [N_IO-1:0]  evt;
    logic [CNT_W-1:0] cnt [N_IO];

    // Bring asynchronous pad levels into the clock domain; nothing between flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.io_in_i;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it differs from filt for more than L edges;
    // the >= compare lets a lowered length take effect at once and never wraps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt <= '0;
            for (int i = 0; i < N_IO; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IO; i++) begin
                if (!bus.filt_en_i[i]) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= bus.filt_len_i) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle-delayed copy of the filtered level for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_d <= '0;
        end else begin
            filt_d <= filt;
        end
    end

    // Edge pulses and the per-pad event selected by the interrupt type
    always_comb begin
        rise = filt & ~filt_d;
        fall = ~filt & filt_d;
        evt  = '0;
        for (int i = 0; i < N_IO; i++) begin
            case (bus.irq_type_i[i])
                2'b00:   evt[i] = rise[i];
                2'b01:   evt[i] = fall[i];
                2'b10:   evt[i] = rise[i] | fall[i];
                default: evt[i] = filt[i];
            endcase
        end
    end

    // Sticky pending flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < N_IO; i++) begin
                if (bus.irq_en_i[i] && evt[i]) begin
                    pend[i] <= 1'b1;
                end else if (bus.irq_clr_i[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.io_filt_o  = filt;
    assign bus.io_rise_o  = rise;
    assign bus.io_fall_o  = fall;
    assign bus.irq_pend_o = pend;
    assign bus.irq_o      = |pend;

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: a bypass vector table plus hand-written
// sequences for glitch rejection, interrupts, length change and reset.
`ifndef N_IO
`define N_IO 50
`endif

module tb_pad_in_filter;
    localparam int N_IO  = `N_IO;
    localparam int CNT_W = 8;

    logic clk_i = 1'b0;
    logic rst_ni;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] in;
        logic [7:0] filt;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    vec_t vecs [9];

    pad_in_filter_if #(.N_IO(N_IO), .CNT_W(CNT_W)) pif ();

    pad_in_filter #(.N_IO(N_IO), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (pif)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drive a pulse of the given width on one pad and tally the filtered response
    task automatic pulse_watch(input int pad, input int width, input int total,
                               output int hi, output int rc, output int fc);
        hi = 0;
        rc = 0;
        fc = 0;
        pif.io_in_i[pad] = 1'b1;
        for (int t = 1; t <= total; t++) begin
            step();
            if (pif.io_filt_o[pad]) hi++;
            if (pif.io_rise_o[pad]) rc++;
            if (pif.io_fall_o[pad]) fc++;
            if (t == width) pif.io_in_i[pad] = 1'b0;
        end
    endtask

    // Main directed sequence
    initial begin
        int hi, rc, fc;

        // bypass table: filt follows the input of two rows earlier
        vecs[0] = '{in: 8'h08, filt: 8'h00, rise: 8'h00, fall: 8'h00};
        vecs[1] = '{in: 8'h08, filt: 8'h00, rise: 8'h00, fall: 8'h00};
        vecs[2] = '{in: 8'h0C, filt: 8'h08, rise: 8'h08, fall: 8'h00};
        vecs[3] = '{in: 8'h04, filt: 8'h08, rise: 8'h00, fall: 8'h00};
        vecs[4] = '{in: 8'h81, filt: 8'h0C, rise: 8'h04, fall: 8'h00};
        vecs[5] = '{in: 8'h00, filt: 8'h04, rise: 8'h00, fall: 8'h08};
        vecs[6] = '{in: 8'h00, filt: 8'h81, rise: 8'h81, fall: 8'h04};
        vecs[7] = '{in: 8'h00, filt: 8'h00, rise: 8'h00, fall: 8'h81};
        vecs[8] = '{in: 8'h00, filt: 8'h00, rise: 8'h00, fall: 8'h00};

        rst_ni         = 1'b0;
        pif.io_in_i    = '0;
        pif.filt_en_i  = '0;
        pif.filt_len_i = '0;
        pif.irq_en_i   = '0;
        pif.irq_type_i = '0;
        pif.irq_clr_i  = '0;

        // reset state, with inputs high to show reset holds everything
        pif.io_in_i = {N_IO{1'b1}};
        step();
        step();
        step();
        check_output("reset filt", pif.io_filt_o, 64'd0);
        check_output("reset rise", pif.io_rise_o, 64'd0);
        check_output("reset pend", pif.irq_pend_o, 64'd0);
        check_output("reset irq", pif.irq_o, 64'd0);
        pif.io_in_i = '0;
        rst_ni = 1'b1;
        step();
        step();
        step();

        // bypass table; pad 2 runs filtered with L=0, which must match bypass
        pif.filt_en_i[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pif.io_in_i = {{(N_IO-8){1'b0}}, vecs[i].in};
            step();
            check_output($sformatf("tbl filt r%0d", i), pif.io_filt_o, 64'(vecs[i].filt));
            check_output($sformatf("tbl rise r%0d", i), pif.io_rise_o, 64'(vecs[i].rise));
            check_output($sformatf("tbl fall r%0d", i), pif.io_fall_o, 64'(vecs[i].fall));
        end
        pif.filt_en_i[2] = 1'b0;

        // glitch rejection on pad 7 with L=4
        pif.filt_en_i[7] = 1'b1;
        pif.filt_len_i   = 8'd4;
        step();
        pulse_watch(7, 4, 25, hi, rc, fc);
        check_output("glitch4 high cycles", 64'(hi), 64'd0);
        check_output("glitch4 rises", 64'(rc), 64'd0);
        check_output("glitch4 falls", 64'(fc), 64'd0);
        pulse_watch(7, 5, 25, hi, rc, fc);
        check_output("pulse5 high cycles", 64'(hi), 64'd5);
        check_output("pulse5 rises", 64'(rc), 64'd1);
        check_output("pulse5 falls", 64'(fc), 64'd1);

        // both-edge interrupt on pad 0 in bypass
        pif.irq_en_i[0]   = 1'b1;
        pif.irq_type_i[0] = 2'b10;
        pif.io_in_i[0]    = 1'b1;
        step();
        step();
        step();
        check_output("irq0 rise pulse", pif.io_rise_o[0], 64'd1);
        check_output("irq0 pend before", pif.irq_pend_o[0], 64'd0);
        step();
        check_output("irq0 pend set", pif.irq_pend_o[0], 64'd1);
        check_output("irq0 irq_o set", pif.irq_o, 64'd1);
        pif.irq_clr_i[0] = 1'b1;
        step();
        pif.irq_clr_i[0] = 1'b0;
        check_output("irq0 pend cleared", pif.irq_pend_o[0], 64'd0);
        check_output("irq0 irq_o cleared", pif.irq_o, 64'd0);
        pif.io_in_i[0] = 1'b0;
        step();
        step();
        step();
        check_output("irq0 fall pulse", pif.io_fall_o[0], 64'd1);
        pif.irq_clr_i[0] = 1'b1;
        step();
        pif.irq_clr_i[0] = 1'b0;
        check_output("irq0 set beats clear", pif.irq_pend_o[0], 64'd1);
        pif.irq_en_i[0] = 1'b0;
        step();
        check_output("irq0 pend after en off", pif.irq_pend_o[0], 64'd1);
        pif.irq_clr_i[0] = 1'b1;
        step();
        pif.irq_clr_i[0] = 1'b0;
        check_output("irq0 final clear", pif.irq_pend_o, 64'd0);

        // level interrupt on pad 1
        pif.irq_en_i[1]   = 1'b1;
        pif.irq_type_i[1] = 2'b11;
        pif.io_in_i[1]    = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_output("lvl pend set", pif.irq_pend_o[1], 64'd1);
        pif.irq_clr_i[1] = 1'b1;
        step();
        pif.irq_clr_i[1] = 1'b0;
        check_output("lvl clear while high", pif.irq_pend_o[1], 64'd1);
        pif.io_in_i[1] = 1'b0;
        step();
        step();
        step();
        check_output("lvl filt low", pif.io_filt_o[1], 64'd0);
        pif.irq_clr_i[1] = 1'b1;
        step();
        pif.irq_clr_i[1] = 1'b0;
        check_output("lvl clear after drop", pif.irq_pend_o[1], 64'd0);
        pif.irq_en_i[1] = 1'b0;

        // length reduced mid-count on pad 10
        pif.filt_en_i[10] = 1'b1;
        pif.filt_len_i    = 8'd200;
        pif.io_in_i[10]   = 1'b1;
        for (int i = 0; i < 52; i++) step();
        check_output("lchg filt at cnt50", pif.io_filt_o[10], 64'd0);
        pif.filt_len_i = 8'd10;
        step();
        check_output("lchg filt updated", pif.io_filt_o[10], 64'd1);
        check_output("lchg rise", pif.io_rise_o[10], 64'd1);

        // reset in the middle of a count on pad 20
        pif.filt_en_i[20] = 1'b1;
        pif.filt_len_i    = 8'd20;
        pif.io_in_i[20]   = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_output("rst pad10 high before", pif.io_filt_o[10], 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_output("rst async filt", pif.io_filt_o, 64'd0);
        check_output("rst async rise", pif.io_rise_o, 64'd0);
        check_output("rst async fall", pif.io_fall_o, 64'd0);
        check_output("rst async pend", pif.irq_pend_o, 64'd0);
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 22; i++) step();
        check_output("rst refill 22 edges", pif.io_filt_o[20], 64'd0);
        step();
        check_output("rst refill 23 edges", pif.io_filt_o[20], 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pad_in_filter.md
PAD_IN_FILTER -- requirements
Module: pad_in_filter

Interface
REQ-001 Parameter N_IO, default `N_IO (50): number of pad inputs handled.
REQ-002 Parameter CNT_W, default 8: width of the glitch-filter counter and length field.
REQ-003 clk_i  input  1  single block clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 io_in_i  input  N_IO  raw pad data, taken from the pad frame io_in_o bus; asynchronous to clk_i.
REQ-006 filt_en_i  input  N_IO  per-pad filter enable; 0 = bypass filter.
REQ-007 filt_len_i  input  CNT_W  shared stability length L, in clk_i cycles.
REQ-008 irq_en_i  input  N_IO  per-pad interrupt enable.
REQ-009 irq_type_i  input  N_IO x 2  per-pad event select: 00 rise, 01 fall, 10 both edges, 11 level high.
REQ-010 irq_clr_i  input  N_IO  per-pad pending clear, one-cycle pulse.
REQ-011 io_filt_o  output  N_IO  synchronised, filtered pad level.
REQ-012 io_rise_o  output  N_IO  one-cycle pulse on filtered 0->1.
REQ-013 io_fall_o  output  N_IO  one-cycle pulse on filtered 1->0.
REQ-014 irq_pend_o  output  N_IO  per-pad sticky pending flag.
REQ-015 irq_o  output  1  OR of all irq_pend_o bits.

Function
REQ-016 Each bit shall pass through a two-flop synchroniser (s1, s2); no logic between the two flops.
REQ-017 Each bit shall hold a filtered register filt, a delayed copy filt_d, and a CNT_W counter cnt.
REQ-018 Bypass (filt_en_i=0): filt <= s2 every edge, and cnt <= 0.
REQ-019 Filter (filt_en_i=1), per edge: if s2 == filt, cnt <= 0; else if cnt >= filt_len_i, filt <= s2 and cnt <= 0; else cnt <= cnt+1.
REQ-020 Latency from an io_in_i change to io_filt_o: 3 edges in bypass and 3+L edges in filter mode. L=0 behaves identically to bypass.
REQ-021 A level at s2 lasting L or fewer cycles shall be rejected: no change on filt.
REQ-022 The cnt >= filt_len_i compare shall make a mid-count reduction of filt_len_i take effect at the next edge. The counter shall never wrap.
REQ-023 Toggling filt_en_i mid-count shall clear cnt. A 1->0 toggle updates filt from s2 at the next edge.
REQ-024 io_filt_o = filt; io_rise_o = filt & ~filt_d; io_fall_o = ~filt & filt_d; filt_d <= filt every edge.
REQ-025 Event per pad: irq_type_i=00 uses rise, 01 uses fall, 10 uses rise|fall, 11 uses filt.
REQ-026 Per edge: if irq_en_i & event, pend <= 1; else if irq_clr_i, pend <= 0; else hold.
REQ-027 A set and a clear in the same cycle shall leave pend at 1.
REQ-028 In level mode, a clear while filt=1 shall leave pend at 1.
REQ-029 Clearing irq_en_i shall not clear an existing pend.
REQ-030 irq_o shall be the combinational OR of all pend bits.
REQ-031 Pads shall be fully independent; no cross-bit interaction except the shared filt_len_i.

Reset
REQ-032 rst_ni low shall asynchronously clear s1, s2, filt, filt_d, cnt and pend for all bits. All outputs read 0.
REQ-033 Reset deassertion is synchronised externally. If io_in_i is held high through reset, the first filtered rise after release is a legitimate event and may set pend.
REQ-034 Reset asserted mid-count shall discard the count; no partial update of filt.

Verification
REQ-035 Bypass: filt_en=0, io_in[3] rises just before edge 0 -> io_filt_o[3]=1 after edge 2, io_rise_o[3] high one cycle after edge 2.
REQ-036 Glitch reject: filt_en=1, L=4, 4-cycle high pulse on io_in[7] -> io_filt_o[7] stays 0, no rise/fall pulse. A 5-cycle pulse -> filt=1 for exactly 5 cycles.
REQ-037 IRQ both edges: irq_en[0]=1, type=10, filtered rise -> pend[0]=1 and irq_o=1. irq_clr pulse -> pend[0]=0. Clear coinciding with a fall event -> pend[0] remains 1.
REQ-038 Level irq: type=11, filt=1, clear pulse -> pend stays 1. Input drops, then clear -> pend=0.
REQ-039 L change: filt_en=1, L=200, cnt reaches 50, L set to 10 -> filt updates on the next edge.
REQ-040 Reset mid-count: L=20, input high 10 cycles, rst_ni pulsed low -> all outputs 0 immediately. After release with input still high -> filt=1 after 3+20 edges.
